// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine: NxN output-stationary systolic matrix multiplier.
// Computes C = A x B with A being NxK, B being KxN and K supplied at start.
// Operands stream in one beat per accepted cycle (A column k from the west,
// B row k from the north). The engine skews them internally so that A(i,k)
// and B(k,j) meet in PE(i,j). Accumulators are read back one row at a time.
// Optional build macro: SYSTOLIC_SAT_EN makes each accumulate saturate
// instead of wrapping modulo 2^AW.
module systolic_mm_engine #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int AW = 64,
  parameter int KW = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*DW-1:0]        west_data,
  input  logic [N*DW-1:0]        north_data,
  output logic                   busy,
  output logic                   done,
  input  logic                   rd_en,
  input  logic [$clog2(N)-1:0]   rd_row,
  output logic                   rd_valid,
  output logic [N*AW-1:0]        rd_data
);

  localparam int RW  = $clog2(N);
  localparam int DCW = $clog2(2 * N);
  // Last drain count: the drain phase lasts 2N-1 cycles (counts 0..2N-2).
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(2 * N - 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_FIN    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_nxt;
  logic [KW-1:0]         r_klen;
  logic [KW-1:0]         r_kcnt;
  logic [DCW-1:0]        r_dcnt;
  logic                  w_accept;
  logic                  w_clear;
  logic                  w_run;
  logic                  r_done;
  logic                  r_rd_valid;
  logic [N*AW-1:0]       r_rd_data;
  logic [N*AW-1:0]       w_row_data;

  logic signed [DW-1:0]  w_west_in  [N];
  logic signed [DW-1:0]  w_north_in [N];
  logic signed [DW-1:0]  w_a_edge   [N];
  logic signed [DW-1:0]  w_b_edge   [N];
  logic signed [DW-1:0]  w_a_in     [N][N];
  logic signed [DW-1:0]  w_b_in     [N][N];
  logic signed [DW-1:0]  r_a        [N][N];
  logic signed [DW-1:0]  r_b        [N][N];
  logic signed [AW-1:0]  r_acc      [N][N];

  // Full-precision signed product, sign-extended to accumulator width.
  function automatic logic signed [AW-1:0] prod_ext(
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b
  );
    logic signed [2*DW-1:0] p;
    p = (2*DW)'(a) * (2*DW)'(b);
    return AW'(p);
  endfunction

`ifdef SYSTOLIC_SAT_EN
  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  // Saturating accumulate: an overflow shows up as the two top bits of the
  // one-bit-wider sum disagreeing; the top bit then tells the direction.
  function automatic logic signed [AW-1:0] acc_add(
    input logic signed [AW-1:0] acc,
    input logic signed [AW-1:0] inc
  );
    logic signed [AW:0] s;
    s = (AW+1)'(acc) + (AW+1)'(inc);
    if (s[AW] != s[AW-1]) begin
      return s[AW] ? ACC_MIN : ACC_MAX;
    end
    return s[AW-1:0];
  endfunction
`else
  // Wrapping accumulate, modulo 2^AW.
  function automatic logic signed [AW-1:0] acc_add(
    input logic signed [AW-1:0] acc,
    input logic signed [AW-1:0] inc
  );
    return acc + inc;
  endfunction
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  // Next-state decode plus handshake and array enables.
  always_comb begin
    w_nxt    = r_state;
    w_accept = 1'b0;
    w_clear  = 1'b0;
    w_run    = 1'b0;
    in_ready = 1'b0;
    busy     = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_clear = 1'b1;
          w_nxt   = (k_len != '0) ? S_STREAM : S_FIN;
        end
      end
      S_STREAM: begin
        in_ready = 1'b1;
        w_run    = 1'b1;
        w_accept = in_valid;
        if (in_valid && (r_kcnt == r_klen - KW'(1))) begin
          w_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_run = 1'b1;
        if (r_dcnt == DRAIN_LAST) begin
          w_nxt = S_FIN;
        end
      end
      S_FIN: begin
        w_nxt = S_IDLE;
      end
      default: begin
        w_nxt = S_IDLE;
      end
    endcase
  end

  // Beat/drain counters and the registered done pulse (one cycle after FIN).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_klen <= '0;
      r_kcnt <= '0;
      r_dcnt <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIN);
      if (w_clear) begin
        r_klen <= k_len;
        r_kcnt <= '0;
      end else if (w_accept) begin
        r_kcnt <= r_kcnt + KW'(1);
      end
      if (r_state == S_DRAIN) begin
        r_dcnt <= r_dcnt + DCW'(1);
      end else begin
        r_dcnt <= '0;
      end
    end
  end

  // Operand entry: an accepted beat is unpacked, anything else is a zero bubble.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_west_in[i]  = w_accept ? west_data[i*DW +: DW]  : '0;
      w_north_in[i] = w_accept ? north_data[i*DW +: DW] : '0;
    end
  end

  // ---- stage boundary: skew lines (row/column i delayed by i cycles) ----
  assign w_a_edge[0] = w_west_in[0];
  assign w_b_edge[0] = w_north_in[0];

  for (genvar gi = 1; gi < N; gi++) begin : g_skew
    logic signed [DW-1:0] r_wsk [gi];
    logic signed [DW-1:0] r_nsk [gi];

    // Delay line so row gi of A and column gi of B reach the array edge gi cycles late.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int d = 0; d < gi; d++) begin
          r_wsk[d] <= '0;
          r_nsk[d] <= '0;
        end
      end else if (w_clear) begin
        for (int d = 0; d < gi; d++) begin
          r_wsk[d] <= '0;
          r_nsk[d] <= '0;
        end
      end else if (w_run) begin
        r_wsk[0] <= w_west_in[gi];
        r_nsk[0] <= w_north_in[gi];
        for (int d = 1; d < gi; d++) begin
          r_wsk[d] <= r_wsk[d-1];
          r_nsk[d] <= r_nsk[d-1];
        end
      end
    end

    assign w_a_edge[gi] = r_wsk[gi-1];
    assign w_b_edge[gi] = r_nsk[gi-1];
  end

  // PE operand routing: A flows east along rows, B flows south along columns.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_a_in[i][0] = w_a_edge[i];
      for (int j = 1; j < N; j++) begin
        w_a_in[i][j] = r_a[i][j-1];
      end
    end
    for (int j = 0; j < N; j++) begin
      w_b_in[0][j] = w_b_edge[j];
      for (int i = 1; i < N; i++) begin
        w_b_in[i][j] = r_b[i-1][j];
      end
    end
  end

  // ---- stage boundary: PE array (operand pass-through and accumulate) ----
  // Array only advances in STREAM/DRAIN so results hold while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_a[i][j]   <= '0;
          r_b[i][j]   <= '0;
          r_acc[i][j] <= '0;
        end
      end
    end else if (w_clear) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_a[i][j]   <= '0;
          r_b[i][j]   <= '0;
          r_acc[i][j] <= '0;
        end
      end
    end else if (w_run) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_a[i][j]   <= w_a_in[i][j];
          r_b[i][j]   <= w_b_in[i][j];
          r_acc[i][j] <= acc_add(r_acc[i][j], prod_ext(w_a_in[i][j], w_b_in[i][j]));
        end
      end
    end
  end

  // Row select for readout.
  always_comb begin
    w_row_data = '0;
    for (int i = 0; i < N; i++) begin
      if (rd_row == RW'(i)) begin
        for (int j = 0; j < N; j++) begin
          w_row_data[j*AW +: AW] = r_acc[i][j];
        end
      end
    end
  end

  // ---- stage boundary: registered readout (ignored while busy) ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else if (rd_en && !busy) begin
      r_rd_valid <= 1'b1;
      r_rd_data  <= w_row_data;
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

  assign done     = r_done;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Self-checking bench for systolic_mm_engine (N=4, DW=32, AW=64).
// Expected C is computed by a plain triple-loop matrix product; latency is
// derived from the first-beat/done timing rule plus counted bubbles.
module tb_systolic_mm_engine;
  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int AW   = 64;
  localparam int KW   = 8;
  localparam int KMAX = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [KW-1:0]        k_len;
  logic                 in_valid;
  logic                 in_ready;
  logic [N*DW-1:0]      west_data;
  logic [N*DW-1:0]      north_data;
  logic                 busy;
  logic                 done;
  logic                 rd_en;
  logic [$clog2(N)-1:0] rd_row;
  logic                 rd_valid;
  logic [N*AW-1:0]      rd_data;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  int     A [N][KMAX];
  int     B [KMAX][N];
  longint Cexp [N][N];

  systolic_mm_engine #(.N(N), .DW(DW), .AW(AW), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .west_data(west_data), .north_data(north_data),
    .busy(busy), .done(done),
    .rd_en(rd_en), .rd_row(rd_row), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
    end
  endtask

  function automatic longint acc_model(input longint a, input longint p);
    longint s;
    s = a + p;
`ifdef SYSTOLIC_SAT_EN
    if (a >= 0 && p >= 0 && s < 0) s = 64'sh7FFF_FFFF_FFFF_FFFF;
    if (a < 0 && p < 0 && s >= 0)  s = 64'sh8000_0000_0000_0000;
`endif
    return s;
  endfunction

  // C(i,j) = sum over k of A(i,k)*B(k,j), accumulated in k order.
  task automatic build_expected(input int K);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        longint acc;
        acc = 0;
        for (int k = 0; k < K; k++) begin
          acc = acc_model(acc, longint'(A[i][k]) * longint'(B[k][j]));
        end
        Cexp[i][j] = acc;
      end
    end
  endtask

  task automatic clear_expected();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        Cexp[i][j] = 0;
  endtask

  task automatic randomize_operands(input int K);
    for (int k = 0; k < K; k++) begin
      for (int i = 0; i < N; i++) begin
        A[i][k] = $urandom;
        B[k][i] = $urandom;
      end
    end
  endtask

  // mode 0: no bubbles, 1: valid only on odd stream cycles, 2: random bubbles.
  // poke: raise start and rd_en mid-stream; both must be ignored.
  task automatic run_product(input int K, input int mode, input bit poke, input string tag);
    int  s_edge, beat, bub, idx, w, exp_lat;
    bit  v;
    @(negedge clk);
    start  = 1'b1;
    k_len  = KW'(K);
    s_edge = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    beat = 0; bub = 0; idx = 0;
    while (beat < K && idx < 400) begin
      if (idx == 0) begin
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      end
      if (poke && idx == 2) check({tag, "_rd_while_busy"}, 64'(rd_valid), 64'd0);
      start = poke && (idx == 1);
      rd_en = poke && (idx == 1);
      case (mode)
        0:       v = 1'b1;
        1:       v = idx[0];
        default: v = ($urandom_range(0, 99) < 65);
      endcase
      in_valid = v;
      for (int i = 0; i < N; i++) begin
        west_data[i*DW +: DW]  = v ? A[i][beat] : $urandom;
        north_data[i*DW +: DW] = v ? B[beat][i] : $urandom;
      end
      if (v && in_ready) beat++;
      else bub++;
      idx++;
      @(negedge clk);
    end
    start = 1'b0;
    rd_en = 1'b0;
    check({tag, "_beats"}, 64'(beat), 64'(K));
    // Garbage offered after the last beat must not be taken.
    in_valid   = 1'b1;
    west_data  = {N{32'hDEAD_BEEF}};
    north_data = {N{32'h1234_5678}};
    check({tag, "_in_ready_after"}, 64'(in_ready), 64'd0);
    w = 0;
    while (done !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    exp_lat = (K == 0) ? 1 : (K + 2 * N + bub);
    check({tag, "_latency"}, 64'(cyc - s_edge), 64'(exp_lat));
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic read_one(input int r);
    @(negedge clk);
    rd_en  = 1'b1;
    rd_row = ($clog2(N))'(r);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic read_rows(input string tag);
    for (int r = 0; r < N; r++) begin
      read_one(r);
      check($sformatf("%s_rdv%0d", tag, r), 64'(rd_valid), 64'd1);
      for (int j = 0; j < N; j++)
        check($sformatf("%s_C%0d%0d", tag, r, j), rd_data[j*AW +: AW], Cexp[r][j]);
    end
  endtask

  task automatic reset_mid_stream();
    bit seen;
    randomize_operands(6);
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(6);
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        west_data[i*DW +: DW]  = A[i][b];
        north_data[i*DW +: DW] = B[b][i];
      end
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_rd_data", rd_data[63:0], 64'd0);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("rst_no_done", 64'(seen), 64'd0);
    clear_expected();
    read_rows("rst");
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0;
    west_data = '0; north_data = '0; rd_en = 1'b0; rd_row = '0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_rd_valid", 64'(rd_valid), 64'd0);
    check("reset_rd_data", rd_data[63:0], 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Identity x B, B(k,j) = 10k + j -> C = B.
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) begin
        A[j][k] = (j == k) ? 1 : 0;
        B[k][j] = 10 * k + j;
      end
    build_expected(4);
    run_product(4, 0, 1'b0, "ident");
    read_rows("ident");
    read_one(2);
    for (int j = 0; j < N; j++)
      check($sformatf("ident_row2_%0d", j), rd_data[j*AW +: AW], 64'(20 + j));

    // Same operands with alternate-cycle bubbles: same C, 4 cycles later.
    run_product(4, 1, 1'b0, "bubble");
    read_rows("bubble");

    // K = 0: accumulators cleared, immediate FIN.
    clear_expected();
    run_product(0, 0, 1'b0, "k0");
    read_rows("k0");

    // All -1 times all 3, K = 5 -> -15 everywhere.
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < N; i++) begin
        A[i][k] = -1;
        B[k][i] = 3;
      end
    build_expected(5);
    run_product(5, 0, 1'b0, "neg");
    read_rows("neg");
    read_one(1);
    check("neg_const", rd_data[2*AW +: AW], 64'hFFFF_FFFF_FFFF_FFF1);

    // start and rd_en raised mid-stream must be ignored.
    randomize_operands(5);
    build_expected(5);
    run_product(5, 0, 1'b1, "poke");
    read_rows("poke");

    // Random operands, random K and random bubbles.
    for (int t = 0; t < 4; t++) begin
      int kr;
      kr = $urandom_range(1, 8);
      randomize_operands(kr);
      build_expected(kr);
      run_product(kr, 2, 1'b0, $sformatf("rnd%0d", t));
      read_rows($sformatf("rnd%0d", t));
    end

    // Two products of 2^62 overflow the 64-bit accumulator.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin
        A[i][k] = 32'h8000_0000;
        B[k][i] = 32'h8000_0000;
      end
    build_expected(2);
    run_product(2, 0, 1'b0, "ovf");
    read_rows("ovf");
    read_one(3);
`ifdef SYSTOLIC_SAT_EN
    check("ovf_const", rd_data[0 +: AW], 64'h7FFF_FFFF_FFFF_FFFF);
`else
    check("ovf_const", rd_data[0 +: AW], 64'h8000_0000_0000_0000);
`endif

    reset_mid_stream();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
